uart_program_loader: RTL and testbench

//  Serial bootloader upstream of the multi-cycle MIPS core. It receives a program over UART,

---
 rtl/uart_program_loader.sv | 218 +++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Serial bootloader: receives a big-endian word count and N big-endian words over UART 8N1.
// Each completed word is written to memory while the CPU is held. UART_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module uart_program_loader #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        load_en,
    output logic        cpu_hold,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] words_loaded,
    output logic        busy,
    output logic        frame_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [1:0] {RX_WAIT_START, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR
`ifdef UART_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          rx_valid, rx_ferr;
    state_t        state, next_state;
    logic          load_en_q, load_rise, load_fall;
    logic [15:0]   word_cnt, hdr_n;
    logic [1:0]    byte_idx;
    logic [23:0]   word;
    logic          last_byte;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]    xsum;
`endif

    // Synchroniser flops idle high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_meta, rx_sync, rx_prev} <= 3'b111;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_WAIT_START;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_WAIT_START: if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START:      if (rx_cnt == HALF_LAST) rx_next = rx_sync ? RX_WAIT_START : RX_BITS;
            RX_BITS:       if (rx_cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:       if (rx_cnt == BIT_LAST) rx_next = RX_WAIT_START;
            default:       rx_next = RX_WAIT_START;
        endcase
    end

    // Bits are sampled mid-cell: half a bit after the falling edge, then one bit apart
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_WAIT_START: begin
                    rx_cnt  <= '0;
                    bit_idx <= '0;
                end
                RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
                RX_BITS: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    assign load_rise = load_en && !load_en_q;
    assign load_fall = !load_en && load_en_q;
    assign hdr_n     = {word_cnt[15:8], rx_shift};
    assign last_byte = rx_valid && (byte_idx == 2'd3);
`ifdef UART_LOADER_CHECKSUM_EN
    assign busy = (state inside {HDR_HI, HDR_LO, DATA, WRITE, CHK});
`else
    assign busy = (state inside {HDR_HI, HDR_LO, DATA, WRITE});
`endif
    assign cpu_hold = load_en | busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Abort on load_en falling outranks a framing error, which outranks normal progress
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        case (state)
            IDLE:   if (load_rise) next_state = HDR_HI;
            HDR_HI: if (rx_valid) next_state = HDR_LO;
            HDR_LO: begin
                if (rx_valid) begin
                    if (hdr_n == 16'd0)     next_state = DONE;
                    else if (hdr_n > MAX_N) next_state = ERROR;
                    else                    next_state = DATA;
                end
            end
            DATA:   if (last_byte) next_state = WRITE;
            WRITE: begin
                mem_we = 1'b1;
                if ((words_loaded + 16'd1) == word_cnt) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = DATA;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CHK:    if (rx_valid) next_state = (rx_shift == xsum) ? DONE : ERROR;
`endif
            DONE, ERROR: if (!load_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (busy && rx_ferr)   next_state = ERROR;
        if (busy && load_fall) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_en_q    <= 1'b0;
            word_cnt     <= '0;
            byte_idx     <= '0;
            word         <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            frame_err    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            xsum         <= '0;
`endif
        end else begin
            load_en_q <= load_en;
            if (state == IDLE && load_rise) begin
                words_loaded <= '0;
                frame_err    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                xsum         <= '0;
`endif
            end
            if (busy && next_state == ERROR) frame_err <= 1'b1;
            if (rx_valid) begin
                case (state)
                    HDR_HI: word_cnt[15:8] <= rx_shift;
                    HDR_LO: begin
                        word_cnt[7:0] <= rx_shift;
                        byte_idx      <= '0;
                    end
                    DATA: begin
                        word     <= {word[15:0], rx_shift};
                        byte_idx <= byte_idx + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        xsum     <= xsum ^ rx_shift;
`endif
                        // Address and data are staged here so they are valid and stable during WRITE
                        if (next_state == WRITE) begin
                            mem_addr  <= {14'd0, words_loaded, 2'b00};
                            mem_wdata <= {word, rx_shift};
                        end
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) words_loaded <= words_loaded + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed boot frames plus randomized frames
// checked against a frame-level model of the expected memory writes and final status.
module tb_uart_program_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        load_en;
    logic        cpu_hold;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [15:0] words_loaded;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int writes_seen = 0;
    int wl_exp;
    bit err_exp;
    int writes_before;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  frame[$];

    uart_program_loader #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000),
        .MAX_WORDS(256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .load_en     (load_en),
        .cpu_hold    (cpu_hold),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .words_loaded(words_loaded),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Every write strobe must match the next write the model predicted
    always @(posedge clk) begin
        #1;
        if (reset) begin
            checkOutput("cpu_hold_rule", cpu_hold, load_en | busy);
            if (mem_we) begin
                writes_seen++;
                checkOutput("write_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) begin
                    checkOutput("mem_addr", mem_addr, exp_addr_q.pop_front());
                    checkOutput("mem_wdata", mem_wdata, exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Runs one load of the bytes in 'frame'; bad_idx gets a zero stop bit, drop_after drops load_en before that byte
    task automatic applyStimulus(input int bad_idx, input int drop_after, input bit glitch,
                                 output int wl, output bit err);
        int lim, good, n, words;
        bit completed;
        lim = frame.size();
        if (drop_after >= 0 && drop_after < lim) lim = drop_after;
        good = (bad_idx >= 0 && bad_idx < lim) ? bad_idx : lim;
        wl = 0;
        err = 1'b0;
        completed = 1'b0;
        if (good >= 2) begin
            n = {frame[0], frame[1]};
            if (n > 256) begin
                err = 1'b1;
            end else begin
                words = (good - 2) / 4;
                if (words > n) words = n;
                for (int w = 0; w < words; w++) begin
                    exp_addr_q.push_back(w * 4);
                    exp_data_q.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
                end
                wl = words;
                completed = (words == n);
            end
        end
        if (good < lim && !completed && !err) err = 1'b1;

        load_en = 1'b0;
        repeat (3) @(negedge clk);
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("start_words_clear", words_loaded, 0);
        checkOutput("start_err_clear", frame_err, 0);
        checkOutput("start_busy", busy, 1);
        if (glitch) begin
            uart_rx = 1'b0;
            repeat (CPB / 4) @(negedge clk);
            uart_rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
        for (int i = 0; i < frame.size(); i++) begin
            if (i == drop_after) break;
            send_byte(frame[i], (i == bad_idx) ? 1'b0 : 1'b1);
            if (i == 0 && bad_idx != 0) checkOutput("busy_after_cnt_hi", busy, 1);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        if (drop_after >= 0 && drop_after < frame.size()) load_en = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("words_loaded", words_loaded, wl);
        checkOutput("frame_err", frame_err, err);
        checkOutput("busy_end", busy, 0);
        checkOutput("cpu_hold_end", cpu_hold, load_en);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("cpu_hold_released", cpu_hold, 0);
        checkOutput("words_kept", words_loaded, wl);
        checkOutput("pending_writes", exp_addr_q.size(), 0);
    endtask

    initial begin
        int n, kind, bad, drop;
        reset = 1'b0;
        uart_rx = 1'b1;
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_cpu_hold", cpu_hold, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_words", words_loaded, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] two-word load");
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00};
        writes_before = writes_seen;
        applyStimulus(-1, -1, 1'b0, wl_exp, err_exp);
        checkOutput("t1_writes", writes_seen - writes_before, 2);
        checkOutput("t1_words", words_loaded, 2);
        checkOutput("t1_last_addr", mem_addr, 32'h4);
        checkOutput("t1_last_data", mem_wdata, 32'hAC02_0000);

        $display("[TB] empty load");
        frame = '{8'h00, 8'h00};
        writes_before = writes_seen;
        applyStimulus(-1, -1, 1'b0, wl_exp, err_exp);
        checkOutput("t2_writes", writes_seen - writes_before, 0);
        checkOutput("t2_words", words_loaded, 0);

        $display("[TB] oversize count");
        frame = '{8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        writes_before = writes_seen;
        applyStimulus(-1, -1, 1'b0, wl_exp, err_exp);
        checkOutput("t3_writes", writes_seen - writes_before, 0);
        checkOutput("t3_err", frame_err, 1);

        $display("[TB] bad stop bit on third data byte");
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00};
        writes_before = writes_seen;
        applyStimulus(4, -1, 1'b0, wl_exp, err_exp);
        checkOutput("t4_writes", writes_seen - writes_before, 0);
        checkOutput("t4_err", frame_err, 1);

        $display("[TB] glitch then valid load");
        applyStimulus(-1, -1, 1'b1, wl_exp, err_exp);
        checkOutput("t5_words", words_loaded, 2);

        $display("[TB] abort after six data bytes");
        frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC};
        applyStimulus(-1, 8, 1'b0, wl_exp, err_exp);
        checkOutput("t6_words", words_loaded, 1);
        checkOutput("t6_data", mem_wdata, 32'h1122_3344);

        $display("[TB] reset during transfer");
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'hDEAD_BEEF);
        frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        reset = 1'b0;
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_words", words_loaded, 0);
        checkOutput("midrst_addr", mem_addr, 0);
        checkOutput("midrst_data", mem_wdata, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pending", exp_addr_q.size(), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] randomized loads");
        for (int r = 0; r < 6; r++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            bad = -1;
            drop = -1;
            frame.delete();
            frame.push_back(8'h00);
            frame.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom_range(0, 255)));
            case (kind)
                0: repeat ($urandom_range(0, 2)) frame.push_back(8'($urandom_range(0, 255)));
                1: bad = $urandom_range(0, frame.size() - 1);
                2: drop = $urandom_range(3, frame.size() - 1);
                default: begin
                    n = $urandom_range(257, 65535);
                    frame[0] = 8'(n >> 8);
                    frame[1] = 8'(n);
                end
            endcase
            applyStimulus(bad, drop, 1'b0, wl_exp, err_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
